carregador_instrucoes: RTL and testbench

//   Program loader: write side of the instruction memory, which the core reads via Endereco/Instrucao.

---
 rtl/carregador_instrucoes_if.sv | 15 +
 rtl/carregador_instrucoes.sv | 92 +++++++++
 tb/tb_carregador_instrucoes.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/carregador_instrucoes_if.sv
// Byte-stream intake and instruction-memory write port of the program loader.
// The slave side is the loader; the master side is the byte source and memory.
interface carregador_instrucoes_if;
  logic [7:0]  ByteEntrada;
  logic        ByteValido;
  logic        ByteAceito;
  logic        EscritaMem;
  logic [31:0] Endereco;
  logic [31:0] Instrucao;

  modport slave  (input  ByteEntrada, ByteValido,
                  output ByteAceito, EscritaMem, Endereco, Instrucao);
  modport master (output ByteEntrada, ByteValido,
                  input  ByteAceito, EscritaMem, Endereco, Instrucao);
endinterface

// File: rtl/carregador_instrucoes.sv
// Program loader: packs an MSB-first byte stream into 32-bit words and writes them
// to consecutive instruction-memory addresses until a jump-to-self or memory full.
module carregador_instrucoes #(
  parameter int         DEPTH   = 123,
  parameter logic [5:0] OP_JUMP = 6'b000101
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    Start,
  carregador_instrucoes_if.slave  bus,
  output logic                    Carregando,
  output logic                    Concluido,
  output logic                    Erro,
  output logic [31:0]             Palavras
);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} estado_t;

  estado_t     estado;
  logic [1:0]  cont_byte;
  logic [23:0] montagem;

  logic halt;
  logic ultimo;
  assign halt   = (bus.Instrucao[31:26] == OP_JUMP) &&
                  (bus.Instrucao[25:0] == bus.Endereco[25:0]);
  assign ultimo = (bus.Endereco == 32'(DEPTH - 1));

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      estado         <= IDLE;
      cont_byte      <= 2'd0;
      montagem       <= 24'd0;
      bus.ByteAceito <= 1'b0;
      bus.EscritaMem <= 1'b0;
      bus.Endereco   <= 32'd0;
      bus.Instrucao  <= 32'd0;
      Carregando     <= 1'b0;
      Concluido      <= 1'b0;
      Erro           <= 1'b0;
      Palavras       <= 32'd0;
    end else begin
      case (estado)
        IDLE, DONE: begin
          if (Start) begin
            estado         <= LOAD;
            cont_byte      <= 2'd0;
            montagem       <= 24'd0;
            bus.Endereco   <= 32'd0;
            Palavras       <= 32'd0;
            Erro           <= 1'b0;
            bus.ByteAceito <= 1'b1;
            Carregando     <= 1'b1;
            Concluido      <= 1'b0;
          end
        end
        LOAD: begin
          if (bus.ByteValido && bus.ByteAceito) begin
            if (cont_byte == 2'd3) begin
              // Fourth byte completes the word; ready drops so the write cycle takes nothing.
              bus.Instrucao  <= {montagem, bus.ByteEntrada};
              cont_byte      <= 2'd0;
              bus.ByteAceito <= 1'b0;
              bus.EscritaMem <= 1'b1;
              estado         <= WRITE;
            end else begin
              montagem  <= {montagem[15:0], bus.ByteEntrada};
              cont_byte <= cont_byte + 2'd1;
            end
          end
        end
        WRITE: begin
          bus.EscritaMem <= 1'b0;
          Palavras       <= Palavras + 32'd1;
          if (halt || ultimo) begin
            // Halt check wins over memory-full, so a halt at the last address is clean.
            estado     <= DONE;
            Erro       <= !halt;
            Carregando <= 1'b0;
            Concluido  <= 1'b1;
          end else begin
            bus.Endereco   <= bus.Endereco + 32'd1;
            bus.ByteAceito <= 1'b1;
            estado         <= LOAD;
          end
        end
        default: estado <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_carregador_instrucoes.sv
// Randomised bench for the program loader, checked against a word-level model of the load.
module tb_carregador_instrucoes;
  localparam int DEPTH = 123;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        Start = 1'b0;
  logic        Carregando, Concluido, Erro;
  logic [31:0] Palavras;

  carregador_instrucoes_if bus();

  carregador_instrucoes #(.DEPTH(DEPTH), .OP_JUMP(6'b000101)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Start      (Start),
    .bus        (bus),
    .Carregando (Carregando),
    .Concluido  (Concluido),
    .Erro       (Erro),
    .Palavras   (Palavras)
  );

  always #5 Clock = ~Clock;

  int nchecks = 0;
  int nerr    = 0;

  logic [7:0]  prog[$];
  logic [31:0] wr_addr[$], wr_data[$];
  logic [31:0] exp_addr[$], exp_data[$];
  bit          exp_erro;
  logic        prev_wr = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Memory-side monitor: record every strobe and insist strobes are isolated.
  always @(negedge Clock) begin
    if (bus.EscritaMem === 1'b1) begin
      wr_addr.push_back(bus.Endereco);
      wr_data.push_back(bus.Instrucao);
      check("strobe_gap", {31'd0, prev_wr}, 32'd0);
    end
    prev_wr = bus.EscritaMem;
  end

  function automatic void add_word(input logic [31:0] w);
    prog.push_back(w[31:24]);
    prog.push_back(w[23:16]);
    prog.push_back(w[15:8]);
    prog.push_back(w[7:0]);
  endfunction

  // Reference: whole words go to address 0,1,2...; stop at jump-to-self or the last address.
  function automatic void build_model();
    logic [31:0] w;
    exp_addr.delete();
    exp_data.delete();
    exp_erro = 1'b0;
    for (int i = 0; i < prog.size() / 4; i++) begin
      w = {prog[4*i], prog[4*i+1], prog[4*i+2], prog[4*i+3]};
      exp_addr.push_back(32'(i));
      exp_data.push_back(w);
      if (w[31:26] == 6'b000101 && w[25:0] == 26'(i)) break;
      if (i == DEPTH - 1) begin
        exp_erro = 1'b1;
        break;
      end
    end
  endfunction

  task automatic pulse_start();
    @(negedge Clock);
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    check("start_carregando", {31'd0, Carregando}, 32'd1);
    check("start_palavras", Palavras, 32'd0);
    check("start_erro", {31'd0, Erro}, 32'd0);
    check("start_aceito", {31'd0, bus.ByteAceito}, 32'd1);
  endtask

  task automatic send_bytes(input int gap_pct, input bit mid_start, output int nacc);
    bit pulsed = 1'b0;
    bit chk_lat = 1'b0;
    bit done, acc;
    int idle;
    nacc = 0;
    for (int i = 0; i < prog.size(); i++) begin
      done = 1'b0;
      idle = 0;
      while (!done && idle < 40) begin
        @(negedge Clock);
        if (chk_lat) begin
          check("strobe_latency", {31'd0, bus.EscritaMem}, 32'd1);
          chk_lat = 1'b0;
        end
        Start = mid_start && !pulsed && nacc == 2;
        if (Start) pulsed = 1'b1;
        bus.ByteEntrada = prog[i];
        bus.ByteValido  = ($urandom_range(99) >= gap_pct);
        acc = bus.ByteValido && bus.ByteAceito;
        @(posedge Clock);
        if (acc) begin
          nacc++;
          done = 1'b1;
          chk_lat = (nacc % 4 == 0);
        end else begin
          idle++;
        end
      end
      if (!done) break;
    end
    @(negedge Clock);
    if (chk_lat) check("strobe_latency", {31'd0, bus.EscritaMem}, 32'd1);
    bus.ByteValido = 1'b0;
    Start = 1'b0;
  endtask

  task automatic run_load(input string tag, input int gap_pct, input bit mid_start);
    int nacc;
    int n;
    wr_addr.delete();
    wr_data.delete();
    build_model();
    pulse_start();
    send_bytes(gap_pct, mid_start, nacc);
    for (int c = 0; c < 20 && Concluido !== 1'b1; c++) @(negedge Clock);
    check({tag, "_concluido"}, {31'd0, Concluido}, 32'd1);
    check({tag, "_consumed"}, 32'(nacc), 32'(exp_addr.size() * 4));
    check({tag, "_nwrites"}, 32'(wr_addr.size()), 32'(exp_addr.size()));
    n = (wr_addr.size() < exp_addr.size()) ? wr_addr.size() : exp_addr.size();
    for (int k = 0; k < n; k++) begin
      check({tag, "_addr"}, wr_addr[k], exp_addr[k]);
      check({tag, "_data"}, wr_data[k], exp_data[k]);
    end
    check({tag, "_erro"}, {31'd0, Erro}, {31'd0, exp_erro});
    check({tag, "_palavras"}, Palavras, 32'(exp_addr.size()));
    check({tag, "_endereco"}, bus.Endereco, exp_addr[exp_addr.size()-1]);
    check({tag, "_carregando"}, {31'd0, Carregando}, 32'd0);
    check({tag, "_aceito"}, {31'd0, bus.ByteAceito}, 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_aceito"}, {31'd0, bus.ByteAceito}, 32'd0);
    check({tag, "_escrita"}, {31'd0, bus.EscritaMem}, 32'd0);
    check({tag, "_endereco"}, bus.Endereco, 32'd0);
    check({tag, "_instrucao"}, bus.Instrucao, 32'd0);
    check({tag, "_carregando"}, {31'd0, Carregando}, 32'd0);
    check({tag, "_concluido"}, {31'd0, Concluido}, 32'd0);
    check({tag, "_erro"}, {31'd0, Erro}, 32'd0);
    check({tag, "_palavras"}, Palavras, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nacc;
    logic [31:0] w;
    bus.ByteEntrada = 8'h00;
    bus.ByteValido  = 1'b0;

    #12;
    check_idle_outputs("reset");
    @(negedge Clock);
    Reset = 1'b1;
    bus.ByteValido = 1'b1;
    repeat (3) @(negedge Clock);
    check("idle_aceito", {31'd0, bus.ByteAceito}, 32'd0);
    bus.ByteValido = 1'b0;

    // T1: two-word program, halt at address 1
    prog.delete();
    add_word(32'h08010009);
    add_word(32'h14000001);
    run_load("t1", 0, 1'b0);
    check("t1_last_data", bus.Instrucao, 32'h14000001);

    // T2: 56 words with a jump elsewhere inside, halt at 55
    prog.delete();
    for (int i = 0; i < 55; i++) begin
      w = $urandom;
      if (w[31:26] == 6'b000101) w[31:26] = 6'b000110;
      if (i == 10) w = {6'b000101, 26'd3};
      add_word(w);
    end
    add_word(32'h14000037);
    run_load("t2", 30, 1'b0);

    // T3: memory fills with no halt; the trailing byte must stay unconsumed
    prog.delete();
    for (int i = 0; i < DEPTH; i++) add_word(32'h30000000);
    prog.push_back(8'hAA);
    run_load("t3", 10, 1'b0);

    // T6: a fresh load after an errored one restarts at 0 with flags cleared
    prog.delete();
    add_word(32'h0000BEEF);
    add_word(32'h14000001);
    run_load("t6", 20, 1'b0);

    // Halt exactly at the last address is a clean finish
    prog.delete();
    for (int i = 0; i < DEPTH - 1; i++) add_word(32'h30000000 | 32'(i));
    add_word({6'b000101, 26'(DEPTH - 1)});
    run_load("halt_last", 5, 1'b0);

    // T4: random gaps and a Start pulse mid-word
    prog.delete();
    add_word(32'h08010009);
    add_word(32'h14000001);
    run_load("t4", 60, 1'b1);

    // T5: reset after two bytes, then a one-word halt program
    wr_addr.delete();
    wr_data.delete();
    prog.delete();
    prog.push_back(8'h14);
    prog.push_back(8'h00);
    pulse_start();
    send_bytes(0, 1'b0, nacc);
    check("t5_partial", 32'(nacc), 32'd2);
    #2 Reset = 1'b0;
    #1 check_idle_outputs("t5_reset");
    repeat (3) @(negedge Clock);
    Reset = 1'b1;
    repeat (2) @(negedge Clock);
    check("t5_no_write", 32'(wr_addr.size()), 32'd0);
    prog.delete();
    add_word(32'h14000000);
    run_load("t5", 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
